// File: rtl/bnd_frame_pkg.sv
// Shared state encodings and drop-cause codes for the boundary-framed receiver.
package bnd_frame_pkg;

    typedef logic [1:0] wr_state_t;
    typedef logic       rd_state_t;

    localparam wr_state_t W_IDLE    = 2'd0;
    localparam wr_state_t W_RECV    = 2'd1;
    localparam wr_state_t W_DISCARD = 2'd2;

    localparam rd_state_t R_IDLE = 1'b0;
    localparam rd_state_t R_SEND = 1'b1;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_SHORT    = 2'b01;
    localparam logic [1:0] CAUSE_LONG     = 2'b10;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b11;

endpackage

// File: rtl/bnd_frame_buf.sv
// Payload RAM with a tentative write pointer that is either committed at
// packet end or rolled back to the last committed position.
module bnd_frame_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              rollback,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_tnt_q, wr_tnt_d;
    logic [AW:0]       wr_cmt_q, wr_cmt_d;
    logic [AW:0]       rd_q, rd_d;
    logic [AW:0]       used_words;

    // Commit captures the pointer including this cycle's word; rollback wins over the write.
    always_comb begin
        wr_tnt_d = wr_tnt_q + {{AW{1'b0}}, wr_en};
        wr_cmt_d = wr_cmt_q;
        if (commit) begin
            wr_cmt_d = wr_tnt_d;
        end
        if (rollback) begin
            wr_tnt_d = wr_cmt_q;
        end
        rd_d = rd_q + {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_tnt_q <= '0;
            wr_cmt_q <= '0;
            rd_q     <= '0;
        end else begin
            wr_tnt_q <= wr_tnt_d;
            wr_cmt_q <= wr_cmt_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_tnt_q[AW-1:0]] <= wr_data;
        end
    end

    assign used_words = wr_tnt_q - rd_q;
    assign full       = (used_words == (AW+1)'(DEPTH));
    assign rd_data    = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/bnd_frame_rx.sv
// Store-and-forward packet receiver: buffers words until the boundary pulse,
// validates length, then forwards committed packets with a valid/ready handshake.
module bnd_frame_rx
    import bnd_frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MIN_LEN   = 2,
    parameter int MAX_LEN   = 8,
    parameter int LEN_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         bnd_plse,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            data_out,
    output logic                         out_last,
    output logic [$clog2(MAX_LEN+1)-1:0] len_out,
    output logic                         pkt_drop,
    output logic [1:0]                   drop_cause,
    output logic [15:0]                  pkt_cnt
);

    localparam int LW  = $clog2(MAX_LEN+1);
    localparam int CW  = $clog2(MAX_LEN+2);
    localparam int DAW = $clog2(LEN_DEPTH);
    localparam int DCW = $clog2(LEN_DEPTH+1);
    localparam logic [CW-1:0]  MIN_L  = CW'(MIN_LEN);
    localparam logic [CW-1:0]  MAX_L  = CW'(MAX_LEN);
    localparam logic [CW-1:0]  OVER_L = CW'(MAX_LEN+1);
    localparam logic [DCW-1:0] DFULL  = DCW'(LEN_DEPTH);

    function automatic logic [DAW-1:0] desc_next(input logic [DAW-1:0] idx);
        return (idx == DAW'(LEN_DEPTH-1)) ? '0 : idx + DAW'(1);
    endfunction

    wr_state_t         w_state_q, w_state_d;
    logic [CW-1:0]     wlen_q, wlen_d, new_len;
    logic              buf_wr, buf_commit, buf_rollback, buf_full, buf_rd;
    logic [DATA_W-1:0] buf_rd_data;
    logic              pkt_drop_q, pkt_drop_d;
    logic [1:0]        drop_cause_q, drop_cause_d;

    logic [LW-1:0]     desc_mem [LEN_DEPTH];
    logic [DAW-1:0]    dwp_q, dwp_d, drp_q, drp_d;
    logic [DCW-1:0]    desc_cnt_q, desc_cnt_d;
    logic              push_q, desc_push, desc_pop, desc_avail;

    rd_state_t         r_state_q, r_state_d;
    logic [LW-1:0]     rlen_q, rlen_d, ridx_q, ridx_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;

    bnd_frame_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (buf_wr),
        .wr_data  (data_in),
        .commit   (buf_commit),
        .rollback (buf_rollback),
        .rd_en    (buf_rd),
        .rd_data  (buf_rd_data),
        .full     (buf_full)
    );

    always_comb begin
        w_state_d    = w_state_q;
        wlen_d       = wlen_q;
        buf_wr       = 1'b0;
        buf_commit   = 1'b0;
        buf_rollback = 1'b0;
        desc_push    = 1'b0;
        pkt_drop_d   = 1'b0;
        drop_cause_d = CAUSE_NONE;
        new_len      = (w_state_q == W_IDLE) ? CW'(1) : wlen_q + CW'(1);
        if (in_valid) begin
            case (w_state_q)
                W_IDLE, W_RECV: begin
                    if (buf_full) begin
                        buf_rollback = 1'b1;
                        pkt_drop_d   = 1'b1;
                        drop_cause_d = CAUSE_OVERFLOW;
                        w_state_d    = bnd_plse ? W_IDLE : W_DISCARD;
                    end else begin
                        buf_wr = 1'b1;
                        wlen_d = new_len;
                        if (bnd_plse) begin
                            w_state_d = W_IDLE;
                            if (new_len < MIN_L || new_len > MAX_L || desc_cnt_q == DFULL) begin
                                buf_rollback = 1'b1;
                                pkt_drop_d   = 1'b1;
                                drop_cause_d = (new_len < MIN_L) ? CAUSE_SHORT :
                                               (new_len > MAX_L) ? CAUSE_LONG : CAUSE_OVERFLOW;
                            end else begin
                                buf_commit = 1'b1;
                                desc_push  = 1'b1;
                            end
                        end else if (new_len == OVER_L) begin
                            buf_rollback = 1'b1;
                            pkt_drop_d   = 1'b1;
                            drop_cause_d = CAUSE_LONG;
                            w_state_d    = W_DISCARD;
                        end else begin
                            w_state_d = W_RECV;
                        end
                    end
                end
                W_DISCARD: begin
                    if (bnd_plse) begin
                        w_state_d = W_IDLE;
                    end
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    // A descriptor pushed last cycle is hidden for one cycle to keep store-and-forward latency.
    assign desc_avail = desc_cnt_q > DCW'(push_q);

    always_comb begin
        r_state_d = r_state_q;
        rlen_d    = rlen_q;
        ridx_d    = ridx_q;
        pkt_cnt_d = pkt_cnt_q;
        desc_pop  = 1'b0;
        buf_rd    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (desc_avail) begin
                    desc_pop  = 1'b1;
                    rlen_d    = desc_mem[drp_q];
                    ridx_d    = '0;
                    r_state_d = R_SEND;
                end
            end
            default: begin
                if (out_ready) begin
                    buf_rd = 1'b1;
                    if (ridx_q == rlen_q - LW'(1)) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        r_state_d = R_IDLE;
                    end else begin
                        ridx_d = ridx_q + LW'(1);
                    end
                end
            end
        endcase
        dwp_d      = desc_push ? desc_next(dwp_q) : dwp_q;
        drp_d      = desc_pop ? desc_next(drp_q) : drp_q;
        desc_cnt_d = desc_cnt_q + DCW'(desc_push) - DCW'(desc_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q    <= W_IDLE;
            wlen_q       <= '0;
            pkt_drop_q   <= 1'b0;
            drop_cause_q <= CAUSE_NONE;
            dwp_q        <= '0;
            drp_q        <= '0;
            desc_cnt_q   <= '0;
            push_q       <= 1'b0;
            r_state_q    <= R_IDLE;
            rlen_q       <= '0;
            ridx_q       <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            w_state_q    <= w_state_d;
            wlen_q       <= wlen_d;
            pkt_drop_q   <= pkt_drop_d;
            drop_cause_q <= drop_cause_d;
            dwp_q        <= dwp_d;
            drp_q        <= drp_d;
            desc_cnt_q   <= desc_cnt_d;
            push_q       <= desc_push;
            r_state_q    <= r_state_d;
            rlen_q       <= rlen_d;
            ridx_q       <= ridx_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (desc_push) begin
            desc_mem[dwp_q] <= new_len[LW-1:0];
        end
    end

    assign out_valid  = (r_state_q == R_SEND);
    assign out_last   = out_valid && (ridx_q == rlen_q - LW'(1));
    assign data_out   = out_valid ? buf_rd_data : '0;
    assign len_out    = rlen_q;
    assign pkt_drop   = pkt_drop_q;
    assign drop_cause = drop_cause_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: doc/bnd_frame_rx.md
BND_FRAME_RX -- requirements
Module: bnd_frame_rx

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, the payload word width.
REQ-002 The block SHALL take parameter DEPTH, default 16, the payload buffer words; it SHALL be a power of 2 and at least 4.
REQ-003 The block SHALL take parameter MIN_LEN, default 2, the shortest legal packet in words.
REQ-004 The block SHALL take parameter MAX_LEN, default 8, the longest legal packet in words; MAX_LEN SHALL be at most DEPTH.
REQ-005 The block SHALL take parameter LEN_DEPTH, default 4, the committed-packet descriptor slots.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  data_in carries a payload word this cycle.
REQ-009 data_in  input  DATA_W  payload word.
REQ-010 bnd_plse  input  1  boundary pulse; when high with in_valid, data_in is the last word of the packet.
REQ-011 out_ready  input  1  downstream accepts data_out this cycle.
REQ-012 out_valid  output  1  data_out is valid.
REQ-013 data_out  output  DATA_W  forwarded payload word.
REQ-014 out_last  output  1  data_out is the final word of its packet.
REQ-015 len_out  output  $clog2(MAX_LEN+1)  word count of the packet being forwarded; held for the whole packet.
REQ-016 pkt_drop  output  1  one-cycle pulse when a packet is discarded.
REQ-017 drop_cause  output  2  00 none, 01 short, 10 long, 11 overflow; valid with pkt_drop.
REQ-018 pkt_cnt  output  16  packets fully forwarded; wraps from 0xFFFF to 0.

Function
REQ-019 The write side SHALL be a state machine with states W_IDLE, W_RECV and W_DISCARD.
REQ-020 W_IDLE with in_valid SHALL write the word and enter W_RECV, or stay in W_IDLE if bnd_plse is also high (1-word packet).
REQ-021 Accepted words SHALL advance a tentative write pointer only; the committed pointer SHALL be unchanged until the packet ends.
REQ-022 A word with bnd_plse SHALL end the packet: if MIN_LEN <= length <= MAX_LEN, commit the pointer and push a length descriptor; otherwise roll back to the committed pointer.
REQ-023 A length reaching MAX_LEN+1 without bnd_plse SHALL roll back, pulse pkt_drop with cause 10 and enter W_DISCARD.
REQ-024 A word arriving when the buffer is full, or a packet end arriving when descriptors are full, SHALL roll back, pulse cause 11 and enter W_DISCARD, or W_IDLE if bnd_plse is high on that word.
REQ-025 W_DISCARD SHALL drop every word up to and including the next word with bnd_plse, then return to W_IDLE with no further pulse.
REQ-026 bnd_plse without in_valid SHALL be ignored.
REQ-027 The read side SHALL be a state machine with states R_IDLE and R_SEND: R_IDLE pops a descriptor when one is available; R_SEND asserts out_valid for len_out words.
REQ-028 A word SHALL transfer only when out_valid and out_ready are both high; data_out, out_last and len_out SHALL hold stable while out_valid is high and out_ready is low.
REQ-029 On the transfer with out_last, pkt_cnt SHALL increment and the read side SHALL return to R_IDLE.
REQ-030 The first word SHALL reach out_valid no earlier than 2 cycles after its packet-ending bnd_plse edge (store-and-forward).
REQ-031 A simultaneous read and write in the same cycle SHALL both proceed; the full and empty conditions SHALL use the committed read pointer against the tentative write pointer.

Reset
REQ-032 While reset is low, all outputs SHALL be 0, both state machines SHALL be in their idle states, and all pointers and counters SHALL be 0.
REQ-033 Reset asserted mid-packet SHALL discard all buffered and in-flight data; the first word after release SHALL be treated as a new packet start.

Structure
REQ-034 The state enums and the drop_cause encodings SHALL be defined in package bnd_frame_pkg.
REQ-035 Payload storage SHALL be a sub-module bnd_frame_buf: a DEPTH x DATA_W dual-pointer RAM with commit and rollback.

Verification (defaults)
REQ-036 A 4-word packet A0..A3 with bnd_plse on A3 and out_ready=1 SHALL yield A0..A3 with len_out=4, out_last on A3, and pkt_cnt=1.
REQ-037 A 1-word packet SHALL produce pkt_drop with cause 01 and no output; a following 2-word packet SHALL forward normally.
REQ-038 A 10-word packet SHALL pulse cause 10 on word 9, absorb word 10 silently, and produce no output.
REQ-039 With out_ready=0, three 6-word packets SHALL commit the first two (12 words) and drop the third with cause 11; raising out_ready SHALL then drain exactly 12 words.
REQ-040 Pulling reset low after 3 words of a packet SHALL leave out_valid=0 after release and pkt_cnt=0, and a following 2-word packet SHALL then pass.
